// File: rtl/eth_fcs_sequencer.sv
// Ethernet TX FCS sequencer: passes payload through, zero-pads to MIN_LEN,
// drives the external byte-wide CRC-32 engine and appends the 4-byte FCS.
module eth_fcs_sequencer #(
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        i_sys_clk,
  input  logic        i_rstn,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_last,
  input  logic        i_ready,
  output logic [7:0]  o_crc_data,
  output logic        o_crc_en,
  output logic        o_crc_done,
  input  logic [31:0] i_crc_fcs,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_DATA,
    ST_PAD,
    ST_CRC_FIN,
    ST_FCS
  } state_t;

  localparam logic [CNT_W:0] MIN_LEN_W = (CNT_W + 1)'(MIN_LEN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fcs_q, fcs_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W:0]   count_inc;
  logic             xfer;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = b[7-k];
    return r;
  endfunction

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    fcs_d      = fcs_q;
    idx_d      = idx_q;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    o_data     = 8'h00;
    o_last     = 1'b0;
    o_crc_done = 1'b0;
    count_inc  = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};

    // NOTE: the DATA pass-through is gated by i_rstn so all outputs read 0 during reset.
    unique case (state_q)
      ST_DATA: begin
        o_ready = i_ready & i_rstn;
        o_valid = i_valid & i_rstn;
        o_data  = i_rstn ? i_data : 8'h00;
      end
      ST_PAD:     o_valid = 1'b1;
      ST_CRC_FIN: o_crc_done = 1'b1;
      ST_FCS: begin
        o_valid = 1'b1;
        o_data  = fcs_q[{idx_q, 3'b000} +: 8];
        o_last  = (idx_q == 2'd3);
      end
      default: ;
    endcase

    xfer = o_valid & i_ready;

    unique case (state_q)
      ST_DATA, ST_PAD: begin
        if (xfer) begin
          count_d = (&count_q) ? count_q : count_inc[CNT_W-1:0];
          if (state_q == ST_DATA && i_last) begin
            state_d = (count_inc < MIN_LEN_W) ? ST_PAD : ST_CRC_FIN;
          end else if (state_q == ST_PAD && count_inc == MIN_LEN_W) begin
            state_d = ST_CRC_FIN;
          end
          if (state_d == ST_CRC_FIN) count_d = '0;
        end
      end
      ST_CRC_FIN: begin
        // Engine register is MSB-first; the wire FCS is its inverted bit reversal.
        for (int k = 0; k < 32; k++) fcs_d[k] = ~i_crc_fcs[31-k];
        idx_d   = 2'd0;
        state_d = ST_FCS;
      end
      ST_FCS: begin
        if (xfer) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_DATA;
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  assign o_crc_en   = xfer & ((state_q == ST_DATA) | (state_q == ST_PAD));
  assign o_crc_data = bitrev8(o_data);
  assign o_busy     = (state_q != ST_DATA) | (count_q != '0);

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge i_sys_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_DATA;
      count_q <= '0;
      fcs_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fcs_q   <= fcs_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_eth_fcs_sequencer.sv
// Bench for eth_fcs_sequencer: instance 0 has MIN_LEN=0, instance 1 MIN_LEN=60.
// Each instance drives a behavioural MSB-first CRC-32 engine; expected bytes come from a reflected reference CRC.
`timescale 1ns/1ps
module tb_eth_fcs_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       iv, il, ir;
  logic [1:0][7:0]  id;
  logic [1:0]       o_rdy, ov, ol, cen, cdone, busy;
  logic [1:0][7:0]  od, cdat;
  logic [1:0][31:0] fcs;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    logic [31:0] eng_q;

    eth_fcs_sequencer #(.MIN_LEN(g == 0 ? 0 : 60), .CNT_W(16)) u_dut (
      .i_sys_clk (clk),
      .i_rstn    (rst_n),
      .i_data    (id[g]),
      .i_valid   (iv[g]),
      .i_last    (il[g]),
      .o_ready   (o_rdy[g]),
      .o_data    (od[g]),
      .o_valid   (ov[g]),
      .o_last    (ol[g]),
      .i_ready   (ir[g]),
      .o_crc_data(cdat[g]),
      .o_crc_en  (cen[g]),
      .o_crc_done(cdone[g]),
      .i_crc_fcs (fcs[g]),
      .o_busy    (busy[g])
    );

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n)         eng_q <= 32'hFFFF_FFFF;
      else if (cdone[g])  eng_q <= 32'hFFFF_FFFF;
      else if (cen[g])    eng_q <= eng_step(eng_q, cdat[g]);
    end

    // Result is only meaningful during the close strobe; poison it otherwise.
    assign fcs[g] = cdone[g] ? eng_q : 32'hDEAD_BEEF;
  end

  function automatic logic [31:0] eng_step(input logic [31:0] r, input logic [7:0] d);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ 32'h04C1_1DB7;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_crc(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   sel = 0;
  bit   mon_en = 1'b0;
  bit   rand_rdy = 1'b0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   en_cnt = 0;
  int   last_seen = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    ir = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      ir = rand_rdy ? 2'($urandom_range(0, 3)) : 2'b11;
    end
  end

  // Scoreboard monitor: samples at the falling edge, away from the active edge.
  initial begin
    bit         hold;
    logic [7:0] hold_d;
    logic       hold_l;
    exp_t       e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
        continue;
      end
      if (cen[sel]) en_cnt++;
      if (ol[sel] && ov[sel] && ir[sel]) last_seen++;
      if (mon_en) begin
        if (hold && ov[sel]) begin
          n_checks++;
          if (od[sel] !== hold_d || ol[sel] !== hold_l) begin
            n_errors++;
            $display("FAIL stall_hold: got data=%02h last=%0b, held data=%02h last=%0b",
                     od[sel], ol[sel], hold_d, hold_l);
          end
        end
        hold = 1'b0;
        if (ov[sel] && !ir[sel]) begin
          hold   = 1'b1;
          hold_d = od[sel];
          hold_l = ol[sel];
        end else if (ov[sel] && ir[sel]) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_byte: got data=%02h last=%0b, expected no output",
                     od[sel], ol[sel]);
          end else begin
            e = sb.pop_front();
            if (od[sel] !== e.data || ol[sel] !== e.last) begin
              n_errors++;
              $display("FAIL out_byte: got data=%02h last=%0b, expected data=%02h last=%0b",
                       od[sel], ol[sel], e.data, e.last);
            end
            if (e.gap >= 0) begin
              n_checks++;
              if (cyc - last_cyc != e.gap) begin
                n_errors++;
                $display("FAIL out_gap: got %0d cycles, expected %0d before byte %02h",
                         cyc - last_cyc, e.gap, e.data);
              end
            end
          end
          last_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input int s, input logic [7:0] p[$], input bit timed);
    logic [7:0]  bf[$];
    logic [31:0] crc;
    int          min_len;
    min_len = (s == 0) ? 0 : 60;
    bf = p;
    while (bf.size() < min_len) bf.push_back(8'h00);
    crc = ref_crc(bf);
    foreach (bf[i]) sb.push_back('{bf[i], 1'b0, (i == 0) ? -1 : (timed ? 1 : -1)});
    for (int k = 0; k < 4; k++)
      sb.push_back('{crc[8*k +: 8], (k == 3), timed ? ((k == 0) ? 2 : 1) : -1});
  endtask

  task automatic send_byte(input int s, input logic [7:0] b, input logic last, output int waits);
    bit acc;
    waits = 0;
    iv[s] = 1'b1;
    id[s] = b;
    il[s] = last;
    forever begin
      @(negedge clk);
      acc = o_rdy[s];
      @(posedge clk);
      #1;
      if (acc) break;
      waits++;
      if (waits > 2000) begin
        n_checks++;
        n_errors++;
        $display("FAIL upstream_accept: got no o_ready in %0d cycles, expected acceptance", waits);
        break;
      end
    end
  endtask

  task automatic send_frame(input int s, input logic [7:0] p[$], output int first_waits);
    int w;
    first_waits = 0;
    foreach (p[i]) begin
      send_byte(s, p[i], (i == p.size() - 1), w);
      if (i == 0) first_waits = w;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d bytes still pending, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic void ascii_frame(output logic [7:0] p[$]);
    p.delete();
    for (int i = 0; i < 9; i++) p.push_back(8'(8'h31 + i));
  endfunction

  task automatic begin_test(input int s);
    sel       = s;
    en_cnt    = 0;
    last_seen = 0;
    mon_en    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv = 2'b11;
    il = 2'b00;
    id = {8'hA5, 8'h5A};
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if ({o_rdy[s], ov[s], ol[s], busy[s], cen[s], cdone[s], od[s], cdat[s]} !== 22'h0) begin
        n_errors++;
        $display("FAIL reset_outputs[%0d]: got rdy=%0b vld=%0b last=%0b busy=%0b en=%0b done=%0b data=%02h crc=%02h, expected all 0",
                 s, o_rdy[s], ov[s], ol[s], busy[s], cen[s], cdone[s], od[s], cdat[s]);
      end
    end
    iv = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ascii_basic();
    logic [7:0] p[$];
    int w;
    begin_test(0);
    ascii_frame(p);
    push_frame(0, p, 1'b1);
    send_frame(0, p, w);
    iv[0] = 1'b0;
    drain();
    check_val("basic_crc_en_count", en_cnt, 9);
    check_val("basic_last_count", last_seen, 1);
    check_val("basic_busy_idle", int'(busy[0]), 0);
  endtask

  task automatic test_pad();
    logic [7:0] p[$];
    int w;
    begin_test(1);
    p.push_back(8'hAA);
    push_frame(1, p, 1'b1);
    send_frame(1, p, w);
    iv[1] = 1'b0;
    check_val("pad_busy", int'(busy[1]), 1);
    drain();
    check_val("pad_crc_en_count", en_cnt, 60);
    check_val("pad_last_count", last_seen, 1);
  endtask

  task automatic test_full_len();
    logic [7:0] p[$];
    int w;
    begin_test(1);
    for (int i = 0; i < 60; i++) p.push_back(8'($urandom_range(0, 255)));
    push_frame(1, p, 1'b1);
    send_frame(1, p, w);
    iv[1] = 1'b0;
    drain();
    check_val("full_crc_en_count", en_cnt, 60);
  endtask

  task automatic test_backpressure();
    logic [7:0] p[$];
    int w;
    begin_test(1);
    rand_rdy = 1'b1;
    for (int i = 0; i < 10; i++) p.push_back(8'($urandom_range(0, 255)));
    push_frame(1, p, 1'b0);
    send_frame(1, p, w);
    iv[1] = 1'b0;
    drain();
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("bp_crc_en_count", en_cnt, 60);
    check_val("bp_last_count", last_seen, 1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] p[$];
    int w1, w2;
    begin_test(0);
    ascii_frame(p);
    push_frame(0, p, 1'b1);
    push_frame(0, p, 1'b0);
    send_frame(0, p, w1);
    send_frame(0, p, w2);
    iv[0] = 1'b0;
    check_val("b2b_ready_low_cycles", w2, 5);
    drain();
    check_val("b2b_last_count", last_seen, 2);
  endtask

  task automatic test_reset_mid();
    logic [7:0] p[$];
    int w;
    begin_test(0);
    mon_en = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(0, 8'(8'h41 + i), 1'b0, w);
    rst_n = 1'b0;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_no_last", last_seen, 0);
    check_val("abort_busy_cleared", int'(busy[0]), 0);
    mon_en = 1'b1;
    ascii_frame(p);
    push_frame(0, p, 1'b1);
    send_frame(0, p, w);
    iv[0] = 1'b0;
    drain();
    check_val("abort_new_last_count", last_seen, 1);
  endtask

  initial begin
    iv = 2'b00;
    il = 2'b00;
    id = '0;
    test_reset();
    test_ascii_basic();
    test_pad();
    test_full_len();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
